// File: rtl/rvv_backend_alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_alu_rs_pkg
// Brief    : Shared ALU reservation-station types, enums and lane counts.
// Revision : 1.0 - initial release
// ============================================================================
package rvv_backend_alu_rs_pkg;

    localparam int ALU_RS_PUSH_NUM = 2;
    localparam int ALU_RS_POP_NUM  = 2;

    typedef enum logic [1:0] {
        EEW_8    = 2'd0,
        EEW_16   = 2'd1,
        EEW_32   = 2'd2,
        EEW_NONE = 2'd3
    } EEW_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SRA = 3'd7
    } ALU_OPCODE_e;

    typedef struct packed {
        logic [4:0]  rob_entry;
        ALU_OPCODE_e opcode;
        EEW_e        vd_eew;
        logic [31:0] vs1_data;
        logic [31:0] vs2_data;
    } ALU_RS_t;

endpackage
`default_nettype wire

// File: rtl/rvv_backend_multi_fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_multi_fifo_ptr
// Brief    : Wrapped read/write pointers and occupancy for a multi-lane FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_backend_multi_fifo_ptr #(
    parameter int DEPTH  = 8,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PUSH_W-1:0] i_push_valid,
    input  logic [POP_W-1:0]  i_pop_req,
    input  logic              i_flush,
    output logic [PUSH_W-1:0] o_push_ready,
    output logic [PUSH_W-1:0] o_push_en,
    output logic [POP_W-1:0]  o_pop_valid,
    output logic [PTR_W-1:0]  o_wr_idx,
    output logic [PTR_W-1:0]  o_rd_idx,
    output logic [PTR_W:0]    o_count
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [PTR_W:0]    w_free;
    logic [PTR_W:0]    w_push_num;
    logic [PTR_W:0]    w_pop_num;
    logic [PUSH_W-1:0] w_push_en;
    logic              w_push_chain;
    logic              w_pop_chain;

    assign w_free = c_DEPTH - r_count;

    // Readiness looks only at the registered count, so there is no bypass.
    generate
        for (genvar i = 0; i < PUSH_W; i++) begin : g_push_ready
            assign o_push_ready[i] = (w_free >= (PTR_W+1)'(i + 1));
        end
        for (genvar i = 0; i < POP_W; i++) begin : g_pop_valid
            assign o_pop_valid[i] = (r_count >= (PTR_W+1)'(i + 1));
        end
    endgenerate

    // A lane only counts when every older lane is also taken.
    always_comb begin
        w_push_num   = '0;
        w_pop_num    = '0;
        w_push_en    = '0;
        w_push_chain = 1'b1;
        w_pop_chain  = 1'b1;
        for (int i = 0; i < PUSH_W; i++) begin
            w_push_chain = w_push_chain & i_push_valid[i] & o_push_ready[i];
            w_push_en[i] = w_push_chain;
            if (w_push_chain) w_push_num = w_push_num + (PTR_W+1)'(1);
        end
        for (int i = 0; i < POP_W; i++) begin
            w_pop_chain = w_pop_chain & i_pop_req[i] & o_pop_valid[i];
            if (w_pop_chain) w_pop_num = w_pop_num + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_num;
            r_rd_ptr <= r_rd_ptr + w_pop_num;
            r_count  <= r_count + w_push_num - w_pop_num;
        end
    end

    assign o_push_en = w_push_en;
    assign o_wr_idx  = r_wr_ptr[PTR_W-1:0];
    assign o_rd_idx  = r_rd_ptr[PTR_W-1:0];
    assign o_count   = r_count;

endmodule
`default_nettype wire

// File: rtl/rvv_backend_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : rvv_backend_alu_rs
// Brief    : ALU reservation station; 2-in/2-out circular queue to the ALUs.
// Revision : 1.0 - initial release
// ============================================================================
module rvv_backend_alu_rs
    import rvv_backend_alu_rs_pkg::*;
#(
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ALU_RS_PUSH_NUM-1:0]           push_valid,
    input  ALU_RS_t [ALU_RS_PUSH_NUM-1:0]        push_data,
    output logic [ALU_RS_PUSH_NUM-1:0]           push_ready,
    output logic [ALU_RS_POP_NUM-1:0]            uop_valid,
    output ALU_RS_t [ALU_RS_POP_NUM-1:0]         uop_data,
    input  logic [ALU_RS_POP_NUM-1:0]            pop_rs,
    input  logic                                 trap_flush,
    output logic [PTR_W:0]                       rs_count,
    output logic                                 rs_empty,
    output logic                                 rs_full
);

    localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

    logic [ALU_RS_PUSH_NUM-1:0] w_push_en;
    logic [PTR_W-1:0]           w_wr_idx;
    logic [PTR_W-1:0]           w_rd_idx;
    logic [PTR_W:0]             w_count;
    ALU_RS_t                    r_entries [DEPTH];

    rvv_backend_multi_fifo_ptr #(
        .DEPTH  (DEPTH),
        .PUSH_W (ALU_RS_PUSH_NUM),
        .POP_W  (ALU_RS_POP_NUM)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (push_valid),
        .i_pop_req    (pop_rs),
        .i_flush      (trap_flush),
        .o_push_ready (push_ready),
        .o_push_en    (w_push_en),
        .o_pop_valid  (uop_valid),
        .o_wr_idx     (w_wr_idx),
        .o_rd_idx     (w_rd_idx),
        .o_count      (w_count)
    );

    // Storage carries no reset; index sums wrap naturally at PTR_W bits.
    always_ff @(posedge clk) begin
        if (!trap_flush) begin
            for (int i = 0; i < ALU_RS_PUSH_NUM; i++) begin
                if (w_push_en[i]) r_entries[w_wr_idx + PTR_W'(i)] <= push_data[i];
            end
        end
    end

    generate
        for (genvar i = 0; i < ALU_RS_POP_NUM; i++) begin : g_rd
            assign uop_data[i] = r_entries[w_rd_idx + PTR_W'(i)];
        end
    endgenerate

    assign rs_count = w_count;
    assign rs_empty = (w_count == '0);
    assign rs_full  = (w_count == c_DEPTH);

    a_push_order: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_valid[1] && !push_valid[0]))
        else $warning("alu_rs: push lane1 without lane0 ignored");

    a_pop_order: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_rs[1] && !pop_rs[0]))
        else $warning("alu_rs: pop_rs[1] without pop_rs[0] ignored");

endmodule
`default_nettype wire

// File: tb/tb_rvv_backend_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvv_backend_alu_rs
// Brief    : Directed + random bench for the ALU reservation station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvv_backend_alu_rs;
    import rvv_backend_alu_rs_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic                 clk;
    logic                 rst_n;
    logic [1:0]           push_valid;
    ALU_RS_t [1:0]        push_data;
    logic [1:0]           push_ready;
    logic [1:0]           uop_valid;
    ALU_RS_t [1:0]        uop_data;
    logic [1:0]           pop_rs;
    logic                 trap_flush;
    logic [PTR_W:0]       rs_count;
    logic                 rs_empty;
    logic                 rs_full;

    int      n_checks = 0;
    int      n_fail   = 0;
    ALU_RS_t q[$];
    ALU_RS_t head_save;

    rvv_backend_alu_rs #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_data  (push_data),
        .push_ready (push_ready),
        .uop_valid  (uop_valid),
        .uop_data   (uop_data),
        .pop_rs     (pop_rs),
        .trap_flush (trap_flush),
        .rs_count   (rs_count),
        .rs_empty   (rs_empty),
        .rs_full    (rs_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic ALU_RS_t mk_uop(input logic [4:0] rob);
        ALU_RS_t u;
        u.rob_entry = rob;
        u.opcode    = ALU_OPCODE_e'($urandom_range(0, 7));
        u.vd_eew    = EEW_e'($urandom_range(0, 3));
        u.vs1_data  = $urandom;
        u.vs2_data  = $urandom;
        return u;
    endfunction

    // Queue model: pops leave from the front, pushes join at the back,
    // and acceptance is judged on the occupancy before the edge.
    task automatic model_update();
        int npop;
        int free;
        if (trap_flush) begin
            q.delete();
        end else begin
            free = DEPTH - q.size();
            npop = 0;
            if (pop_rs[0]) npop = pop_rs[1] ? 2 : 1;
            if (npop > q.size()) npop = q.size();
            repeat (npop) void'(q.pop_front());
            if (push_valid[0] && free >= 1) q.push_back(push_data[0]);
            if (push_valid[0] && push_valid[1] && free >= 2) q.push_back(push_data[1]);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = q.size();
        check_eq("count", rs_count, sz);
        check_eq("uop_valid", uop_valid, {sz >= 2, sz >= 1});
        check_eq("push_ready", push_ready, {(DEPTH - sz) >= 2, (DEPTH - sz) >= 1});
        check_eq("empty", rs_empty, sz == 0);
        check_eq("full", rs_full, sz == DEPTH);
        if (sz >= 1) check_eq("uop0", uop_data[0], q[0]);
        if (sz >= 2) check_eq("uop1", uop_data[1], q[1]);
    endtask

    task automatic drive_cycle(input logic [1:0] pv, input ALU_RS_t d0, input ALU_RS_t d1,
                               input logic [1:0] pr, input logic fl);
        push_valid   = pv;
        push_data[0] = d0;
        push_data[1] = d1;
        pop_rs       = pr;
        trap_flush   = fl;
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic rnd_cycle(input logic [1:0] pv, input logic [1:0] pr, input logic fl);
        drive_cycle(pv, mk_uop(5'($urandom)), mk_uop(5'($urandom)), pr, fl);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_count"}, rs_count, 0);
        check_eq({tag, "_valid"}, uop_valid, 2'b00);
        check_eq({tag, "_ready"}, push_ready, 2'b11);
        check_eq({tag, "_empty"}, rs_empty, 1'b1);
        check_eq({tag, "_full"}, rs_full, 1'b0);
    endtask

    initial begin
        logic [1:0] pv;
        logic [1:0] pr;

        rst_n      = 1'b0;
        push_valid = 2'b00;
        pop_rs     = 2'b00;
        trap_flush = 1'b0;
        push_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle, then a dual push becomes visible one cycle later.
        repeat (5) rnd_cycle(2'b00, 2'b00, 1'b0);
        drive_cycle(2'b11, mk_uop(5'd3), mk_uop(5'd4), 2'b00, 1'b0);
        check_eq("first_rob0", uop_data[0].rob_entry, 5'd3);
        check_eq("first_rob1", uop_data[1].rob_entry, 5'd4);
        rnd_cycle(2'b00, 2'b11, 1'b0);

        // Fill to 7, then a 2-lane push takes only lane0.
        repeat (3) rnd_cycle(2'b11, 2'b00, 1'b0);
        rnd_cycle(2'b01, 2'b00, 1'b0);
        check_eq("seven_ready", push_ready, 2'b01);
        rnd_cycle(2'b11, 2'b00, 1'b0);
        check_eq("full_count", rs_count, 8);
        check_eq("full_flag", rs_full, 1'b1);
        check_eq("full_ready", push_ready, 2'b00);
        rnd_cycle(2'b11, 2'b01, 1'b0);
        check_eq("full_pop_count", rs_count, 7);
        check_eq("full_pop_ready", push_ready, 2'b01);

        // Drain, then walk the pointers round to physical slot 7.
        repeat (3) rnd_cycle(2'b00, 2'b11, 1'b0);
        rnd_cycle(2'b00, 2'b01, 1'b0);
        rnd_cycle(2'b11, 2'b00, 1'b0);
        rnd_cycle(2'b11, 2'b00, 1'b0);
        rnd_cycle(2'b01, 2'b00, 1'b0);
        rnd_cycle(2'b00, 2'b11, 1'b0);
        rnd_cycle(2'b00, 2'b11, 1'b0);
        rnd_cycle(2'b00, 2'b01, 1'b0);
        check_eq("pre_wrap_empty", rs_empty, 1'b1);
        drive_cycle(2'b11, mk_uop(5'd10), mk_uop(5'd11), 2'b00, 1'b0);
        check_eq("wrap_rob0", uop_data[0].rob_entry, 5'd10);
        check_eq("wrap_rob1", uop_data[1].rob_entry, 5'd11);
        rnd_cycle(2'b00, 2'b11, 1'b0);
        check_eq("wrap_drained", rs_count, 0);

        // Out-of-order pop request removes nothing.
        drive_cycle(2'b11, mk_uop(5'd20), mk_uop(5'd21), 2'b00, 1'b0);
        drive_cycle(2'b01, mk_uop(5'd22), mk_uop(5'd23), 2'b00, 1'b0);
        head_save = uop_data[0];
        rnd_cycle(2'b00, 2'b10, 1'b0);
        check_eq("illegal_pop_count", rs_count, 3);
        check_eq("illegal_pop_head", uop_data[0], head_save);
        rnd_cycle(2'b00, 2'b01, 1'b0);
        check_eq("single_pop_count", rs_count, 2);
        check_eq("single_pop_head", uop_data[0].rob_entry, 5'd21);

        // Flush overrides a same-cycle push and pop.
        rnd_cycle(2'b11, 2'b00, 1'b0);
        rnd_cycle(2'b01, 2'b00, 1'b0);
        check_eq("pre_flush_count", rs_count, 5);
        rnd_cycle(2'b11, 2'b11, 1'b1);
        check_reset_outputs("flush");

        // Asynchronous reset between clock edges.
        rnd_cycle(2'b11, 2'b00, 1'b0);
        rnd_cycle(2'b11, 2'b00, 1'b0);
        check_eq("pre_reset_count", rs_count, 4);
        push_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        #1 rst_n = 1'b1;
        rnd_cycle(2'b01, 2'b00, 1'b0);
        check_eq("post_reset_count", rs_count, 1);

        // Random legal traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       pv = 2'b00;
                1:       pv = 2'b01;
                default: pv = 2'b11;
            endcase
            case ($urandom_range(0, 3))
                0:       pr = 2'b00;
                1:       pr = 2'b01;
                default: pr = 2'b11;
            endcase
            rnd_cycle(pv, pr, ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
